pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic, parametrised pipeline stage register for the 5-stage MIPS core.
//  Replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
//  Adds a valid/ready handshake, stall, flush and an optional 2-entry skid buffer.
//  Bubbles carry an all-zero payload; IR=0 decodes as sll $0,$0,0, i.e. a nop.
// PARAMETERS
//  DW     160  payload width in bits (MEM/WB: IR,PC4,AO,DR,MEMdata = 5x32)
//  SKID   0    0: single register, combinational in_ready; 1: 2-entry skid, registered in_ready
//  CNT_W  16   width of the stall statistic counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  flush      in   1      synchronous pipeline flush (branch/exception squash)
//  in_valid   in   1      upstream beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_data    in   DW     upstream payload
//  out_valid  out  1      downstream beat valid
//  out_ready  in   1      downstream accepts (0 = stall)
//  out_data   out  DW     payload to next stage; all-zero whenever out_valid=0
//  stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  - Reset (clk edge with reset=1): all valids=0, all payload regs=0, stall_cnt=0, state EMPTY.
//    Outputs after reset: out_valid=0, out_data=0, in_ready=1.
//  - Priority per edge: reset > flush > normal handshake.
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready. in_ready is forced 0 while flush=1.
//  - Latency: an accepted beat appears on out_data at the next edge (1 cycle), in both modes.
//  - SKID=0: one register. in_ready = ~flush & (out_ready | ~out_valid), so it depends
//    combinationally on out_ready. Accept loads the register. Pop without accept loads 0s and
//    clears valid. Accept and pop on the same edge give full throughput.
//  - SKID=1: main reg (drives out_*) plus skid reg. in_ready = ~flush & ~skid_valid, from registers only.
//    States: EMPTY, ONE (main full), TWO (main+skid full).
//      EMPTY: accept -> ONE.
//      ONE:   accept&pop -> ONE (main<=in); accept&~pop -> TWO (skid<=in);
//             pop&~accept -> EMPTY (main<=0).
//      TWO:   pop -> ONE (main<=skid, skid<=0). No accept is possible (in_ready=0).
//    Order is preserved: skid contents always leave before any newer beat.
//  - Flush: all valids->0, all payload regs->0, state->EMPTY, stall_cnt unchanged.
//    No beat is accepted during the flush cycle. in_ready=1 from the next cycle.
//    A downstream pop in the flush cycle still completes; the beat is seen once.
//  - stall_cnt: +1 on each edge with out_valid & ~out_ready. Saturates at 2^CNT_W-1.
//    It does not wrap and is cleared only by reset.
//  - out_data is never X. Payload regs are all-zero whenever their valid bit is 0.
//  - Reset or flush mid-stall (state TWO) drops both held beats. No partial state survives.
// STRUCTURE
//  - Shared package pipe_pkg: state encodings ST_EMPTY/ST_ONE/ST_TWO; NOP_PAYLOAD='0;
//    MEM/WB field offsets (IR_LO, PC4_LO, AO_LO, DR_LO, MD_LO) and width constants for
//    packing and unpacking the payload.
//  - One natural sub-module: pipe_skid_ctl. It holds the 3-state FSM plus the valid bits and
//    produces the load/select enables for the main and skid registers.
//    It is instantiated only when SKID=1 (generate); SKID=0 uses inline single-register logic.
//  - Top level holds the datapath regs and the stall counter. Each of the four pipeline
//    stages instantiates pipe_stage_buf with its own DW.
// TESTING
//  1. Reset: hold reset 2 cycles with in_valid=1, in_data=0xA5.. -> out_valid=0, out_data=0,
//     stall_cnt=0, in_ready=1 afterwards.
//  2. Streaming (both SKID modes): out_ready=1, send beats 1..8 back-to-back ->
//     out_data is 1..8 on consecutive cycles, 1-cycle latency, no gaps.
//  3. Stall fill (SKID=1): out_ready=0, offer 3 beats 0x11,0x22,0x33 -> 0x11 and 0x22 accepted,
//     in_ready=0 on the 3rd. Release -> 0x11,0x22,0x33 in order, none lost or duplicated.
//  4. Flush in TWO: state holds 0x11/0x22, pulse flush with in_valid=1, in_data=0x44 ->
//     next cycle out_valid=0, out_data=0, 0x44 not accepted, in_ready=1.
//  5. Stall counter: CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15
//     (saturated). A flush leaves 15; reset gives 0.
//  6. Bubble: SKID=0, one beat 0x7 then in_valid=0 with out_ready=1 ->
//     out_data=0x7 for one cycle, then 0 with out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: skid FSM encodings, bubble
// payload and the MEM/WB payload field layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

    localparam int WORD_W = 32;

    // MEM/WB payload layout, low word first
    localparam int IR_LO  = 0;
    localparam int PC4_LO = 32;
    localparam int AO_LO  = 64;
    localparam int DR_LO  = 96;
    localparam int MD_LO  = 128;

    localparam int IFID_DW  = 2 * WORD_W;
    localparam int IDEX_DW  = 4 * WORD_W;
    localparam int EXMEM_DW = 4 * WORD_W;
    localparam int MEMWB_DW = 5 * WORD_W;

    // All-zero IR decodes as sll $0,$0,0, so a zero payload is a nop bubble.
    localparam logic [MEMWB_DW-1:0] NOP_PAYLOAD = '0;

    typedef struct packed {
        logic [WORD_W-1:0] md;
        logic [WORD_W-1:0] dr;
        logic [WORD_W-1:0] ao;
        logic [WORD_W-1:0] pc4;
        logic [WORD_W-1:0] ir;
    } memwb_t;

    function automatic logic [MEMWB_DW-1:0] pack_memwb(
        input logic [WORD_W-1:0] ir,
        input logic [WORD_W-1:0] pc4,
        input logic [WORD_W-1:0] ao,
        input logic [WORD_W-1:0] dr,
        input logic [WORD_W-1:0] md
    );
        logic [MEMWB_DW-1:0] p;
        p = NOP_PAYLOAD;
        p[IR_LO  +: WORD_W] = ir;
        p[PC4_LO +: WORD_W] = pc4;
        p[AO_LO  +: WORD_W] = ao;
        p[DR_LO  +: WORD_W] = dr;
        p[MD_LO  +: WORD_W] = md;
        return p;
    endfunction

    function automatic logic [WORD_W-1:0] memwb_field(
        input logic [MEMWB_DW-1:0] p,
        input int                  lo
    );
        return p[lo +: WORD_W];
    endfunction

endpackage

// File: rtl/pipe_skid_ctl.sv
// Control for the 2-entry skid variant: occupancy FSM, valid bits and the
// load/clear enables for the main and skid payload registers.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_EMPTY | no beat held, main and skid payloads zero
//   ST_ONE   | main holds the oldest beat, skid empty
//   ST_TWO   | main holds the oldest beat, skid the next one
module pipe_skid_ctl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic main_valid,
    output logic main_load_in,
    output logic main_load_skid,
    output logic main_clear,
    output logic skid_load_in,
    output logic skid_clear
);

    skid_state_e state;
    logic        skid_valid;
    logic        accept;
    logic        pop;

    assign in_ready = ~flush & ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign pop      = main_valid & out_ready;

    always_comb begin
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load_in   = 1'b0;
        skid_clear     = 1'b0;
        case (state)
            ST_EMPTY: main_load_in = accept;
            ST_ONE: begin
                main_load_in = accept & pop;
                skid_load_in = accept & ~pop;
                main_clear   = pop & ~accept;
            end
            ST_TWO: begin
                main_load_skid = pop;
                skid_clear     = pop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state      <= ST_EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state      <= ST_ONE;
                        main_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        state      <= ST_TWO;
                        skid_valid <= 1'b1;
                    end else if (pop && !accept) begin
                        state      <= ST_EMPTY;
                        main_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state      <= ST_ONE;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register with valid/ready handshake, flush,
// optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DW    = 160,
    parameter int SKID  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [DW-1:0] BUBBLE = DW'(NOP_PAYLOAD);

    logic          main_valid;
    logic [DW-1:0] main_data;

    generate
        if (SKID != 0) begin : g_skid
            logic          main_load_in;
            logic          main_load_skid;
            logic          main_clear;
            logic          skid_load_in;
            logic          skid_clear;
            logic [DW-1:0] skid_data;

            pipe_skid_ctl u_ctl (
                .clk            (clk),
                .reset          (reset),
                .flush          (flush),
                .in_valid       (in_valid),
                .out_ready      (out_ready),
                .in_ready       (in_ready),
                .main_valid     (main_valid),
                .main_load_in   (main_load_in),
                .main_load_skid (main_load_skid),
                .main_clear     (main_clear),
                .skid_load_in   (skid_load_in),
                .skid_clear     (skid_clear)
            );

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    main_data <= BUBBLE;
                    skid_data <= BUBBLE;
                end else begin
                    if (main_load_in) begin
                        main_data <= in_data;
                    end else if (main_load_skid) begin
                        main_data <= skid_data;
                    end else if (main_clear) begin
                        main_data <= BUBBLE;
                    end
                    if (skid_load_in) begin
                        skid_data <= in_data;
                    end else if (skid_clear) begin
                        skid_data <= BUBBLE;
                    end
                end
            end
        end else begin : g_single
            logic accept;
            logic pop;

            // in_ready looks through to out_ready so a full register can refill as it drains
            assign in_ready = ~flush & (out_ready | ~main_valid);
            assign accept   = in_valid & in_ready;
            assign pop      = main_valid & out_ready;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    main_valid <= 1'b0;
                    main_data  <= BUBBLE;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                end else if (pop) begin
                    main_valid <= 1'b0;
                    main_data  <= BUBBLE;
                end
            end
        end
    endgenerate

    // Counts across flush too; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one single-register and one skid instance share
// stimulus, each tracked by its own queue-based occupancy model.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [31:0] out_data0, out_data1;
    logic [3:0]  stall0, stall1;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          sc0 = 0;
    int          sc1 = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DW(32), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .stall_cnt(stall0)
    );

    pipe_stage_buf #(.DW(32), .SKID(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .stall_cnt(stall1)
    );

    // Reference: a FIFO of capacity 1 (ready may look at out_ready) or 2 (ready only when not full).
    always @(posedge clk) begin
        bit a0, a1;
        if (reset) begin
            q0.delete(); q1.delete(); sc0 = 0; sc1 = 0;
        end else begin
            if (q0.size() > 0 && !out_ready && sc0 < 15) sc0++;
            if (q1.size() > 0 && !out_ready && sc1 < 15) sc1++;
            if (flush) begin
                q0.delete(); q1.delete();
            end else begin
                a0 = in_valid && (out_ready || q0.size() == 0);
                a1 = in_valid && (q1.size() < 2);
                if (q0.size() > 0 && out_ready) void'(q0.pop_front());
                if (q1.size() > 0 && out_ready) void'(q1.pop_front());
                if (a0) q0.push_back(in_data);
                if (a1) q1.push_back(in_data);
            end
        end
    end

    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
        @(negedge clk);
        reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 1, 32'hA5A5_A5A5, 0);
        cyc(1, 0, 1, 32'hA5A5_A5A5, 0);
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid0 got %b want 0", out_valid0); end
        checks++; if (out_data0 !== 32'h0) begin errors++; $display("FAIL reset_out_data0 got %h want 0", out_data0); end
        checks++; if (stall0 !== 4'd0) begin errors++; $display("FAIL reset_stall0 got %0d want 0", stall0); end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready0 got %b want 1", in_ready0); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got %b want 0", out_valid1); end
        checks++; if (out_data1 !== 32'h0) begin errors++; $display("FAIL reset_out_data1 got %h want 0", out_data1); end
        checks++; if (stall1 !== 4'd0) begin errors++; $display("FAIL reset_stall1 got %0d want 0", stall1); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready1 got %b want 1", in_ready1); end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 32'(i), 1);
            checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
                errors++; $display("FAIL stream_in_ready beat %0d got %b/%b want 1/1", i, in_ready0, in_ready1);
            end
            if (i > 1) begin
                checks++; if (out_valid0 !== 1'b1 || out_data0 !== 32'(i - 1)) begin
                    errors++; $display("FAIL stream_data0 got %b/%h want 1/%h", out_valid0, out_data0, 32'(i - 1));
                end
                checks++; if (out_valid1 !== 1'b1 || out_data1 !== 32'(i - 1)) begin
                    errors++; $display("FAIL stream_data1 got %b/%h want 1/%h", out_valid1, out_data1, 32'(i - 1));
                end
            end
        end
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (out_data0 !== 32'd8 || out_data1 !== 32'd8) begin
            errors++; $display("FAIL stream_last got %h/%h want 8/8", out_data0, out_data1);
        end
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || out_data0 !== 32'h0 || out_data1 !== 32'h0) begin
            errors++; $display("FAIL stream_drain got %b/%b %h/%h want 0/0 0/0", out_valid0, out_valid1, out_data0, out_data1);
        end
    endtask

    task automatic test_stall_fill();
        cyc(0, 0, 1, 32'h11, 0);
        checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            errors++; $display("FAIL fill_first got rdy=%b vld=%b want 1/0", in_ready1, out_valid1);
        end
        cyc(0, 0, 1, 32'h22, 0);
        checks++; if (in_ready1 !== 1'b1 || out_data1 !== 32'h11) begin
            errors++; $display("FAIL fill_second got rdy=%b data=%h want 1/11", in_ready1, out_data1);
        end
        cyc(0, 0, 1, 32'h33, 0);
        checks++; if (in_ready1 !== 1'b0 || out_data1 !== 32'h11) begin
            errors++; $display("FAIL fill_full got rdy=%b data=%h want 0/11", in_ready1, out_data1);
        end
        cyc(0, 0, 1, 32'h33, 1);
        checks++; if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_data1 !== 32'h11) begin
            errors++; $display("FAIL release_1 got rdy=%b vld=%b data=%h want 0/1/11", in_ready1, out_valid1, out_data1);
        end
        cyc(0, 0, 1, 32'h33, 1);
        checks++; if (in_ready1 !== 1'b1 || out_data1 !== 32'h22) begin
            errors++; $display("FAIL release_2 got rdy=%b data=%h want 1/22", in_ready1, out_data1);
        end
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 32'h33) begin
            errors++; $display("FAIL release_3 got vld=%b data=%h want 1/33", out_valid1, out_data1);
        end
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== 32'h0) begin
            errors++; $display("FAIL release_empty got vld=%b data=%h want 0/0", out_valid1, out_data1);
        end
    endtask

    task automatic test_flush_two();
        cyc(0, 0, 1, 32'h11, 0);
        cyc(0, 0, 1, 32'h22, 0);
        cyc(0, 0, 0, 32'h0, 0);
        checks++; if (out_data1 !== 32'h11 || in_ready1 !== 1'b0) begin
            errors++; $display("FAIL flush_pre got data=%h rdy=%b want 11/0", out_data1, in_ready1);
        end
        cyc(0, 1, 1, 32'h44, 0);
        checks++; if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin
            errors++; $display("FAIL flush_rdy_forced got %b/%b want 0/0", in_ready0, in_ready1);
        end
        cyc(0, 0, 0, 32'h0, 0);
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== 32'h0 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL flush_post got vld=%b data=%h rdy=%b want 0/0/1", out_valid1, out_data1, in_ready1);
        end
        checks++; if (out_valid0 !== 1'b0 || out_data0 !== 32'h0) begin
            errors++; $display("FAIL flush_post0 got vld=%b data=%h want 0/0", out_valid0, out_data0);
        end
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== 32'h0) begin
            errors++; $display("FAIL flush_no_accept got vld=%b data=%h want 0/0", out_valid1, out_data1);
        end
    endtask

    task automatic test_stall_counter();
        cyc(1, 0, 0, 32'h0, 1);
        cyc(0, 0, 1, 32'h5, 0);
        checks++; if (stall1 !== 4'd0) begin errors++; $display("FAIL stall_start got %0d want 0", stall1); end
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 32'h0, 0);
            if (i == 5) begin
                checks++; if (stall1 !== 4'd5 || stall0 !== 4'd5) begin
                    errors++; $display("FAIL stall_mid got %0d/%0d want 5/5", stall0, stall1);
                end
            end
        end
        cyc(0, 1, 0, 32'h0, 0);
        checks++; if (stall1 !== 4'd15 || stall0 !== 4'd15) begin
            errors++; $display("FAIL stall_sat got %0d/%0d want 15/15", stall0, stall1);
        end
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (stall1 !== 4'd15 || out_valid1 !== 1'b0) begin
            errors++; $display("FAIL stall_after_flush got %0d vld=%b want 15/0", stall1, out_valid1);
        end
        cyc(1, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (stall1 !== 4'd0 || stall0 !== 4'd0) begin
            errors++; $display("FAIL stall_reset got %0d/%0d want 0/0", stall0, stall1);
        end
    endtask

    task automatic test_bubble();
        cyc(0, 0, 1, 32'h7, 1);
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (out_valid0 !== 1'b1 || out_data0 !== 32'h7) begin
            errors++; $display("FAIL bubble_beat got vld=%b data=%h want 1/7", out_valid0, out_data0);
        end
        cyc(0, 0, 0, 32'h0, 1);
        checks++; if (out_valid0 !== 1'b0 || out_data0 !== 32'h0) begin
            errors++; $display("FAIL bubble_zero got vld=%b data=%h want 0/0", out_valid0, out_data0);
        end
    endtask

    task automatic test_random();
        logic        f, iv, ordy;
        logic [31:0] d;
        logic        e_rdy0, e_rdy1, e_vld0, e_vld1;
        logic [31:0] e_dat0, e_dat1;
        cyc(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 400; i++) begin
            f    = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) < 2);
            d    = $urandom();
            cyc(0, f, iv, d, ordy);
            e_vld0 = (q0.size() > 0);
            e_vld1 = (q1.size() > 0);
            e_dat0 = e_vld0 ? q0[0] : 32'h0;
            e_dat1 = e_vld1 ? q1[0] : 32'h0;
            e_rdy0 = !f && (ordy || q0.size() == 0);
            e_rdy1 = !f && (q1.size() < 2);
            checks++; if (in_ready0 !== e_rdy0) begin errors++; $display("FAIL rnd_in_ready0 cyc %0d got %b want %b", i, in_ready0, e_rdy0); end
            checks++; if (in_ready1 !== e_rdy1) begin errors++; $display("FAIL rnd_in_ready1 cyc %0d got %b want %b", i, in_ready1, e_rdy1); end
            checks++; if (out_valid0 !== e_vld0) begin errors++; $display("FAIL rnd_out_valid0 cyc %0d got %b want %b", i, out_valid0, e_vld0); end
            checks++; if (out_valid1 !== e_vld1) begin errors++; $display("FAIL rnd_out_valid1 cyc %0d got %b want %b", i, out_valid1, e_vld1); end
            checks++; if (out_data0 !== e_dat0) begin errors++; $display("FAIL rnd_out_data0 cyc %0d got %h want %h", i, out_data0, e_dat0); end
            checks++; if (out_data1 !== e_dat1) begin errors++; $display("FAIL rnd_out_data1 cyc %0d got %h want %h", i, out_data1, e_dat1); end
            checks++; if (stall0 !== 4'(sc0)) begin errors++; $display("FAIL rnd_stall0 cyc %0d got %0d want %0d", i, stall0, sc0); end
            checks++; if (stall1 !== 4'(sc1)) begin errors++; $display("FAIL rnd_stall1 cyc %0d got %0d want %0d", i, stall1, sc1); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush_two();
        test_stall_counter();
        test_bubble();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
